// File: rtl/ibex_fetch_aligner.sv
// rtl/ibex_fetch_aligner.sv - realigns a word-aligned fetch stream into 16/32-bit instructions
module ibex_fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_is_compressed_o,
  output logic [31:0] out_pc_o,
  output logic        out_err_o
);

  // S_ALIGNED: next instruction starts at the low half of the incoming word.
  // S_STASH:   next instruction starts at the stashed upper half of the previous word.
  // S_SKIP:    branch target is the upper half; the low half of the next word is dead.
  typedef enum logic [1:0] {
    S_ALIGNED = 2'd0,
    S_STASH   = 2'd1,
    S_SKIP    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] stash_q, stash_d;
  logic        stash_err_q, stash_err_d;

  logic        lo_is_comp;
  logic        hi_is_comp;
  logic        stash_is_comp;
  logic        out_fire;

  assign lo_is_comp    = (fetch_rdata_i[1:0] != 2'b11);
  assign hi_is_comp    = (fetch_rdata_i[17:16] != 2'b11);
  assign stash_is_comp = (stash_q[1:0] != 2'b11);
  assign out_fire      = out_valid_o & out_ready_i;

  assign out_pc_o            = pc_q;
  assign out_is_compressed_o = (out_instr_o[1:0] != 2'b11);

  // Next-state, output and consume decisions; branch and reset take priority.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stash_d       = stash_q;
    stash_err_d   = stash_err_q;
    out_valid_o   = 1'b0;
    out_instr_o   = 32'h0000_0000;
    out_err_o     = 1'b0;
    fetch_ready_o = 1'b0;

    if (rst_i) begin
      // Outputs held quiet; the register block applies the reset values.
      state_d = S_ALIGNED;
    end else if (branch_i) begin
      // Drop whatever word is in flight and restart at the target halfword.
      fetch_ready_o = 1'b1;
      pc_d          = branch_addr_i & 32'hFFFF_FFFE;
      stash_d       = 16'h0000;
      stash_err_d   = 1'b0;
      state_d       = branch_addr_i[1] ? S_SKIP : S_ALIGNED;
    end else begin
      unique case (state_q)
        S_ALIGNED: begin
          if (fetch_valid_i) begin
            out_valid_o = 1'b1;
            out_err_o   = fetch_err_i;
            if (lo_is_comp) begin
              out_instr_o = {16'h0000, fetch_rdata_i[15:0]};
              if (out_fire) begin
                fetch_ready_o = 1'b1;
                stash_d       = fetch_rdata_i[31:16];
                stash_err_d   = fetch_err_i;
                pc_d          = pc_q + 32'd2;
                state_d       = S_STASH;
              end
            end else begin
              out_instr_o = fetch_rdata_i;
              if (out_fire) begin
                fetch_ready_o = 1'b1;
                pc_d          = pc_q + 32'd4;
              end
            end
          end
        end

        S_STASH: begin
          if (stash_is_comp) begin
            // Whole instruction already held locally; the fetch word is left untouched.
            out_valid_o = 1'b1;
            out_instr_o = {16'h0000, stash_q};
            out_err_o   = stash_err_q;
            if (out_fire) begin
              pc_d    = pc_q + 32'd2;
              state_d = S_ALIGNED;
            end
          end else if (fetch_valid_i) begin
            // Spanning instruction: upper half comes from the new word's low half.
            out_valid_o = 1'b1;
            out_instr_o = {fetch_rdata_i[15:0], stash_q};
            out_err_o   = stash_err_q | fetch_err_i;
            if (out_fire) begin
              fetch_ready_o = 1'b1;
              stash_d       = fetch_rdata_i[31:16];
              stash_err_d   = fetch_err_i;
              pc_d          = pc_q + 32'd4;
            end
          end
        end

        S_SKIP: begin
          if (fetch_valid_i) begin
            if (hi_is_comp) begin
              out_valid_o = 1'b1;
              out_instr_o = {16'h0000, fetch_rdata_i[31:16]};
              out_err_o   = fetch_err_i;
              if (out_fire) begin
                fetch_ready_o = 1'b1;
                pc_d          = pc_q + 32'd2;
                state_d       = S_ALIGNED;
              end
            end else begin
              // Upper half starts a 32-bit instruction; keep it and wait for the next word.
              fetch_ready_o = 1'b1;
              stash_d       = fetch_rdata_i[31:16];
              stash_err_d   = fetch_err_i;
              state_d       = S_STASH;
            end
          end
        end

        default: begin
          state_d = S_ALIGNED;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_ALIGNED;
      pc_q        <= BOOT_ADDR;
      stash_q     <= 16'h0000;
      stash_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stash_q     <= stash_d;
      stash_err_q <= stash_err_d;
    end
  end

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// tb/tb_ibex_fetch_aligner.sv - directed and scoreboard-checked streams for ibex_fetch_aligner
module tb_ibex_fetch_aligner;

  logic        clk_i;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic        fetch_ready_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic        out_is_compressed_o;
  logic [31:0] out_pc_o;
  logic        out_err_o;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  ibex_fetch_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_rdata_i       (fetch_rdata_i),
    .fetch_err_i         (fetch_err_i),
    .fetch_ready_o       (fetch_ready_o),
    .branch_i            (branch_i),
    .branch_addr_i       (branch_addr_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_instr_o         (out_instr_o),
    .out_is_compressed_o (out_is_compressed_o),
    .out_pc_o            (out_pc_o),
    .out_err_o           (out_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    next_cyc();
    rst_i         = 1'b1;
    branch_i      = 1'b0;
    fetch_valid_i = 1'b0;
    out_ready_i   = 1'b0;
    fetch_err_i   = 1'b0;
    next_cyc();
    rst_i = 1'b0;
  endtask

  task automatic drive(input logic fv, input logic [31:0] w, input logic fe, input logic rdy);
    fetch_valid_i = fv;
    fetch_rdata_i = w;
    fetch_err_i   = fe;
    out_ready_i   = rdy;
  endtask

  task automatic check_out(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic comp, input logic fr);
    check({tag, "_valid"}, out_valid_o, 1);
    check({tag, "_instr"}, out_instr_o, instr);
    check({tag, "_pc"}, out_pc_o, pc);
    check({tag, "_comp"}, out_is_compressed_o, comp);
    check({tag, "_fready"}, fetch_ready_o, fr);
  endtask

  function automatic logic [15:0] rand_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1) == 1) h[1:0] = 2'b11;
    else h[1:0] = 2'($urandom_range(2));
    return h;
  endfunction

  // Branch to a random target and push a word stream; expectations come from
  // walking the halfword sequence independently of any state machine.
  task automatic run_stream(input int nw);
    logic [31:0] words[$];
    logic        werrs[$];
    logic [15:0] hw[$];
    logic        herr[$];
    logic [31:0] addr;
    logic [31:0] pc;
    int          i;
    int          idx;
    int          cyc;
    logic        hold;
    exp_t        e;

    addr = {$urandom, 1'b0} & 32'hFFFF_FFFE;
    addr[1] = 1'($urandom_range(1));
    for (int k = 0; k < nw; k++) begin
      logic [31:0] w;
      logic        er;
      w  = {rand_hw(), rand_hw()};
      er = ($urandom_range(7) == 0);
      words.push_back(w);
      werrs.push_back(er);
      hw.push_back(w[15:0]);
      hw.push_back(w[31:16]);
      herr.push_back(er);
      herr.push_back(er);
    end

    i  = addr[1] ? 1 : 0;
    pc = addr;
    while (i < hw.size()) begin
      if (hw[i][1:0] != 2'b11) begin
        e.instr = {16'h0000, hw[i]};
        e.pc = pc; e.comp = 1'b1; e.err = herr[i];
        sb.push_back(e);
        pc = pc + 32'd2;
        i  = i + 1;
      end else if (i + 1 < hw.size()) begin
        e.instr = {hw[i+1], hw[i]};
        e.pc = pc; e.comp = 1'b0; e.err = herr[i] | herr[i+1];
        sb.push_back(e);
        pc = pc + 32'd4;
        i  = i + 2;
      end else begin
        break;
      end
    end

    next_cyc();
    branch_i      = 1'b1;
    branch_addr_i = addr | 32'($urandom_range(1));
    drive(1'($urandom_range(1)), $urandom, 1'b0, 1'($urandom_range(1)));
    @(negedge clk_i);
    check("br_valid", out_valid_o, 0);
    check("br_fready", fetch_ready_o, 1);

    idx  = 0;
    cyc  = 0;
    hold = 1'b0;
    next_cyc();
    branch_i = 1'b0;
    fetch_valid_i = 1'b0;
    while ((idx < nw || sb.size() > 0) && cyc < 300) begin
      if (cyc > 0) next_cyc();
      cyc++;
      if (!hold) begin
        if (idx < nw && $urandom_range(3) != 0) begin
          drive(1'b1, words[idx], werrs[idx], 1'b0);
        end else begin
          fetch_valid_i = 1'b0;
        end
      end
      out_ready_i = ($urandom_range(3) != 0);
      @(negedge clk_i);
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          check("sb_spurious", out_valid_o, 0);
        end else begin
          check("sb_instr", out_instr_o, sb[0].instr);
          check("sb_pc", out_pc_o, sb[0].pc);
          check("sb_comp", out_is_compressed_o, sb[0].comp);
          check("sb_err", out_err_o, sb[0].err);
          if (out_ready_i) void'(sb.pop_front());
        end
      end
      if (fetch_ready_o && !fetch_valid_i) check("sb_fready_no_word", fetch_ready_o, 0);
      if (fetch_valid_i && fetch_ready_o) begin
        idx++;
        hold = 1'b0;
      end else begin
        hold = fetch_valid_i;
      end
    end
    check("stream_done", (idx == nw && sb.size() == 0), 1);
    next_cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk_i);
    check("stream_idle_valid", out_valid_o, 0);
    sb.delete();
  endtask

  initial begin
    rst_i         = 1'b1;
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0200;
    drive(1'b1, 32'h00A0_0513, 1'b0, 1'b1);

    // Reset dominates branch and keeps both handshakes low.
    @(negedge clk_i);
    check("rst_valid", out_valid_o, 0);
    check("rst_fready", fetch_ready_o, 0);
    next_cyc();
    @(negedge clk_i);
    check("rst_valid2", out_valid_o, 0);
    next_cyc();
    rst_i    = 1'b0;
    branch_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    check("rst_pc", out_pc_o, 32'h80);
    check("rst_idle_valid", out_valid_o, 0);

    // Aligned 32-bit instruction.
    do_reset();
    drive(1'b1, 32'h00A0_0513, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("w32", 32'h00A0_0513, 32'h80, 1'b0, 1'b1);
    next_cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk_i);
    check("w32_next_pc", out_pc_o, 32'h84);
    check("w32_next_valid", out_valid_o, 0);

    // Two compressed instructions in one word; second needs no fetch word.
    do_reset();
    drive(1'b1, 32'h4505_4501, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("c16a", 32'h0000_4501, 32'h80, 1'b1, 1'b1);
    next_cyc();
    drive(1'b1, 32'h1111_2222, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("c16b", 32'h0000_4505, 32'h82, 1'b1, 1'b0);

    // Spanning instruction, then the stashed zero halfword; errors propagate.
    do_reset();
    drive(1'b1, 32'h0513_4501, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("spa", 32'h0000_4501, 32'h80, 1'b1, 1'b1);
    check("spa_err", out_err_o, 0);
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      drive(1'b1, 32'h0000_00A0, 1'b1, 1'b0);
      @(negedge clk_i);
      check_out("stall", 32'h00A0_0513, 32'h82, 1'b0, 1'b0);
      check("stall_err", out_err_o, 1);
    end
    next_cyc();
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check_out("spb", 32'h00A0_0513, 32'h82, 1'b0, 1'b1);
    check("spb_err", out_err_o, 1);
    next_cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    check_out("stash0", 32'h0000_0000, 32'h86, 1'b1, 1'b0);
    check("stash0_err", out_err_o, 1);

    // Branch to an odd halfword; bit 0 of the target is ignored.
    next_cyc();
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0103;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    @(negedge clk_i);
    check("br_valid", out_valid_o, 0);
    check("br_fready", fetch_ready_o, 1);
    next_cyc();
    branch_i = 1'b0;
    drive(1'b1, 32'h4505_FFFF, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("skip", 32'h0000_4505, 32'h102, 1'b1, 1'b1);
    next_cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk_i);
    check("skip_next_pc", out_pc_o, 32'h104);
    check("skip_next_valid", out_valid_o, 0);

    // Skip where the upper half starts a 32-bit instruction.
    next_cyc();
    branch_i      = 1'b1;
    branch_addr_i = 32'h0000_0102;
    @(negedge clk_i);
    next_cyc();
    branch_i = 1'b0;
    drive(1'b1, 32'h0513_FFFF, 1'b0, 1'b0);
    @(negedge clk_i);
    check("skip32_valid", out_valid_o, 0);
    check("skip32_fready", fetch_ready_o, 1);
    next_cyc();
    drive(1'b1, 32'h0000_00A0, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("skip32", 32'h00A0_0513, 32'h102, 1'b0, 1'b1);

    // PC wraps modulo 2^32.
    next_cyc();
    branch_i      = 1'b1;
    branch_addr_i = 32'hFFFF_FFFF;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk_i);
    next_cyc();
    branch_i = 1'b0;
    drive(1'b1, 32'h0001_1234, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("wrap", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b1);
    next_cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk_i);
    check("wrap_pc", out_pc_o, 32'h0);

    // Reset while a compressed stash is pending discards it.
    do_reset();
    drive(1'b1, 32'h4505_4501, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("pre_rst", 32'h0000_4501, 32'h80, 1'b1, 1'b1);
    next_cyc();
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk_i);
    check("midrst_valid", out_valid_o, 0);
    check("midrst_fready", fetch_ready_o, 0);
    next_cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("postrst_valid", out_valid_o, 0);
    check("postrst_pc", out_pc_o, 32'h80);
    next_cyc();
    drive(1'b1, 32'h00A0_0513, 1'b0, 1'b1);
    @(negedge clk_i);
    check_out("postrst", 32'h00A0_0513, 32'h80, 1'b0, 1'b1);

    // Randomised streams against the halfword model.
    for (int s = 0; s < 12; s++) begin
      run_stream(4 + int'($urandom_range(8)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ibex_fetch_aligner.md
IBEX_FETCH_ALIGNER -- requirements
Module: ibex_fetch_aligner

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0080, reset value of the PC register.
REQ-002 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports fetch_valid_i in 1, fetch_rdata_i in 32, fetch_err_i in 1: word-aligned fetch word, little-endian halfwords, bus error flag.
REQ-005 SHALL have port fetch_ready_o  out  1  asserted in the cycle the current fetch word is consumed.
REQ-006 SHALL have ports branch_i in 1, branch_addr_i in 32: redirect request and target; bit 0 ignored.
REQ-007 SHALL have ports out_valid_o out 1, out_ready_i in 1: instruction handshake toward the decoder.
REQ-008 SHALL have ports out_instr_o out 32, out_is_compressed_o out 1, out_pc_o out 32, out_err_o out 1: raw instruction (16-bit instructions zero-extended), compressed flag (instr[1:0] != 2'b11), its PC, fetch error.

Function
REQ-009 SHALL hold state: pc_q[31:0], stash_q[15:0], stash_err_q, FSM state in {S_ALIGNED, S_STASH, S_SKIP}.
REQ-010 S_ALIGNED, word valid, w[1:0] != 11: SHALL emit {16'b0,w[15:0]}, compressed; on out handshake consume word, stash w[31:16], go S_STASH.
REQ-011 S_ALIGNED, word valid, w[1:0] == 11: SHALL emit w, uncompressed; on out handshake consume word, stay S_ALIGNED.
REQ-012 S_STASH, stash_q[1:0] != 11: SHALL emit {16'b0,stash_q} without requiring fetch_valid_i; fetch_ready_o = 0; on handshake go S_ALIGNED.
REQ-013 S_STASH, stash_q[1:0] == 11: SHALL wait for fetch_valid_i, emit {w[15:0],stash_q}; on handshake consume word, stash w[31:16], stay S_STASH.
REQ-014 S_SKIP, word valid: SHALL discard w[15:0]; if w[17:16] != 11 emit {16'b0,w[31:16]} and on handshake consume, go S_ALIGNED; else consume word with no output, stash w[31:16], go S_STASH.
REQ-015 out_valid_o SHALL be 0 whenever the required fetch word is absent; fetch_ready_o SHALL be asserted only when the word is consumed per REQ-010..014 (combinational on out_ready_i).
REQ-016 While out_valid_o=1 and out_ready_i=0, all out_* SHALL remain stable (fetch side holds data while fetch_valid_i=1 and fetch_ready_o=0).
REQ-017 On each out handshake pc_q SHALL advance by 2 (compressed) or 4 (uncompressed), modulo 2^32.
REQ-018 out_err_o SHALL be fetch_err_i for single-word emits, stash_err_q for compressed stash emits, stash_err_q OR fetch_err_i for spanning emits; stash_err_q SHALL load fetch_err_i on every stash.
REQ-019 Erroneous instruction SHALL still advance PC normally; no other side effect.
REQ-020 branch_i=1 SHALL override all: out_valid_o=0, fetch_ready_o=1 (in-flight word dropped), next pc_q={branch_addr_i[31:1],1'b0}, stash cleared, next state S_SKIP if branch_addr_i[1] else S_ALIGNED.
REQ-021 Zero-latency: instruction available combinationally in the cycle its last halfword is presented; max throughput one instruction per cycle.

Reset
REQ-022 rst_i=1 at a clock edge SHALL set pc_q=BOOT_ADDR, state S_ALIGNED, stash_q=0, stash_err_q=0; rst_i overrides branch_i.
REQ-023 While rst_i=1, out_valid_o=0 and fetch_ready_o=0; reset mid-stash SHALL discard the stash.

Verification
REQ-024 Reset, word 32'h00A0_0513 valid, out_ready_i=1 -> out_instr_o=32'h00A0_0513, compressed=0, out_pc_o=32'h80, fetch_ready_o=1; next pc 32'h84.
REQ-025 Word 32'h4505_4501 -> cycle 1 emit 32'h0000_4501 pc 0x80 (word consumed); cycle 2 emit 32'h0000_4505 pc 0x82, fetch_ready_o=0.
REQ-026 Words 32'h0513_4501 then 32'h0000_00A0 -> emit 32'h4501 pc 0x80, then 32'h00A0_0513 pc 0x82 spanning, stash=0000 and state S_STASH.
REQ-027 branch_i=1, branch_addr_i=32'h0000_0102, then word 32'h4505_FFFF -> low half discarded, emit 32'h0000_4505 pc 0x102.
REQ-028 Spanning emit with fetch_err_i=1 only on second word -> out_err_o=1; out_ready_i held 0 for 3 cycles -> all outputs stable, fetch_ready_o=0.
REQ-029 rst_i asserted while in S_STASH with valid stash -> next cycle out_valid_o=0, out_pc_o=BOOT_ADDR, stash discarded.
